// File: rtl/regfile_sb.sv
// Parametrised register file with a per-register pending-write scoreboard.
// Decode reads and issues here; writeback writes and retires pending bits.
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter bit BYPASS = 1'b1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_addr,
  input  logic [AW-1:0]     dbg_addr,
  output logic [XLEN-1:0]   dbg_data
);

  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] pending;

  function automatic logic addr_ok(
    input logic [AW-1:0] a
  );
    return (a != '0) && (int'(a) < NREGS);
  endfunction

  logic wr_ok;
  logic iss_ok;

  assign wr_ok  = we && addr_ok(wr_addr);
  assign iss_ok = issue_valid && addr_ok(issue_addr);

  // Entry 0 is only ever cleared, so it stays a constant zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i]    <= '0;
        pending[i] <= 1'b0;
      end
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (wr_ok && wr_addr == AW'(i))
          regs[i] <= wr_data;
        if (iss_ok && issue_addr == AW'(i))
          pending[i] <= 1'b1;
        else if (wr_ok && wr_addr == AW'(i))
          pending[i] <= 1'b0;
      end
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] ra;
    logic          ok;
    logic          hit;

    assign ra  = rd_addr[p*AW +: AW];
    assign ok  = addr_ok(ra);
    assign hit = BYPASS && wr_ok && (wr_addr == ra);

    always_comb begin
      rd_data[p*XLEN +: XLEN] = '0;
      rd_busy[p]              = 1'b0;
      if (ok) begin
        if (hit) begin
          rd_data[p*XLEN +: XLEN] = wr_data;
        end else begin
          rd_data[p*XLEN +: XLEN] = regs[ra];
          rd_busy[p]              = pending[ra];
        end
      end
    end
  end

  assign dbg_data = addr_ok(dbg_addr) ? regs[dbg_addr] : '0;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: two instances (24x32 bypass, 3 ports;
// 32x32 no bypass, 2 ports) share stimulus and are checked against a model.
module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_addr = '0;
  logic [4:0]  dbg_addr = '0;
  logic [14:0] rd_addr0 = '0;
  logic [9:0]  rd_addr1;
  logic [95:0] rd_data0;
  logic [2:0]  rd_busy0;
  logic [31:0] dbg_data0;
  logic [63:0] rd_data1;
  logic [1:0]  rd_busy1;
  logic [31:0] dbg_data1;

  assign rd_addr1 = rd_addr0[9:0];

  regfile_sb #(
    .XLEN(32), .NREGS(24), .NRD(3), .BYPASS(1'b1)
  ) u_bp (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr0), .rd_data(rd_data0), .rd_busy(rd_busy0),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data0)
  );

  regfile_sb #(
    .XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1'b0)
  ) u_nb (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr1), .rd_data(rd_data1), .rd_busy(rd_busy1),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data1)
  );

  typedef struct packed {
    logic [95:0] d0;
    logic [2:0]  b0;
    logic [31:0] g0;
    logic [63:0] d1;
    logic [1:0]  b1;
    logic [31:0] g1;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   started = 1'b0;

  // Reference state: k=0 is the bypass instance, k=1 the plain one.
  logic [31:0] mem [2][32];
  bit          pend [2][32];

  function automatic int nregs(input int k);
    return (k == 0) ? 24 : 32;
  endfunction

  function automatic logic [31:0] stored(input int k, input int a);
    if (a == 0 || a >= nregs(k)) return 32'd0;
    return mem[k][a];
  endfunction

  function automatic void m_read(input int k, input int a,
                                 output logic [31:0] d,
                                 output logic b);
    d = 32'd0;
    b = 1'b0;
    if (a == 0 || a >= nregs(k)) return;
    if (k == 0 && we && int'(wr_addr) == a) begin
      d = wr_data;
    end else begin
      d = mem[k][a];
      b = pend[k][a];
    end
  endfunction

  function automatic void m_edge();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        for (int i = 0; i < 32; i++) begin
          mem[k][i]  = 32'd0;
          pend[k][i] = 1'b0;
        end
      end else begin
        if (we && wr_addr != 0 && int'(wr_addr) < nregs(k)) begin
          mem[k][wr_addr]  = wr_data;
          pend[k][wr_addr] = 1'b0;
        end
        if (issue_valid && issue_addr != 0 &&
            int'(issue_addr) < nregs(k))
          pend[k][issue_addr] = 1'b1;
      end
    end
  endfunction

  function automatic exp_t predict();
    exp_t x;
    logic [31:0] d;
    logic b;
    x = '0;
    for (int p = 0; p < 3; p++) begin
      m_read(0, int'(rd_addr0[p*5 +: 5]), d, b);
      x.d0[p*32 +: 32] = d;
      x.b0[p] = b;
    end
    for (int p = 0; p < 2; p++) begin
      m_read(1, int'(rd_addr0[p*5 +: 5]), d, b);
      x.d1[p*32 +: 32] = d;
      x.b1[p] = b;
    end
    x.g0 = stored(0, int'(dbg_addr));
    x.g1 = stored(1, int'(dbg_addr));
    return x;
  endfunction

  function automatic void chk(input string n, input logic [95:0] a,
                              input logic [95:0] x);
    n_chk++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s t=%0t got %h want %h", n, $time, a, x);
    end
  endfunction

  task automatic cyc(input bit c, input logic r, input logic w,
                     input logic [4:0] wa, input logic [31:0] wd,
                     input logic iv, input logic [4:0] ia,
                     input logic [4:0] a0, input logic [4:0] a1,
                     input logic [4:0] a2, input logic [4:0] da);
    @(posedge clk);
    #1;
    if (started) m_edge();
    started     = 1'b1;
    reset       = r;
    we          = w;
    wr_addr     = wa;
    wr_data     = wd;
    issue_valid = iv;
    issue_addr  = ia;
    rd_addr0    = {a2, a1, a0};
    dbg_addr    = da;
    if (c) q.push_back(predict());
  endtask

  function automatic logic [4:0] rnd_a();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  always @(negedge clk) begin
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("bp_rd_data", rd_data0, e.d0);
      chk("bp_rd_busy", 96'(rd_busy0), 96'(e.b0));
      chk("bp_dbg", 96'(dbg_data0), 96'(e.g0));
      chk("nb_rd_data", 96'(rd_data1), 96'(e.d1));
      chk("nb_rd_busy", 96'(rd_busy1), 96'(e.b1));
      chk("nb_dbg", 96'(dbg_data1), 96'(e.g1));
    end
  end

  initial begin
    logic [4:0] wa;
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 5, 1, 23, 5);
    cyc(1, 0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 5, 0, 5);
    cyc(1, 0, 0, 0, 0, 1, 5, 5, 0, 0, 5);
    cyc(1, 0, 0, 0, 0, 0, 0, 5, 5, 5, 5);
    cyc(1, 1, 1, 5, 32'h1234, 1, 5, 5, 5, 5, 5);
    cyc(1, 0, 0, 0, 0, 0, 0, 5, 5, 5, 5);
    cyc(1, 0, 1, 1, 32'd50, 0, 0, 2, 1, 1, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1);
    cyc(1, 0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 3, 3, 3, 0, 3);
    cyc(1, 0, 0, 0, 0, 0, 0, 3, 3, 3, 3);
    cyc(1, 0, 0, 0, 0, 0, 0, 3, 3, 3, 3);
    cyc(1, 0, 1, 3, 32'd25, 0, 0, 3, 3, 3, 3);
    cyc(1, 0, 0, 0, 0, 0, 0, 3, 3, 3, 3);
    cyc(1, 0, 1, 7, 32'd77, 1, 7, 7, 7, 7, 7);
    cyc(1, 0, 0, 0, 0, 0, 0, 7, 7, 7, 7);
    cyc(1, 0, 0, 0, 0, 0, 0, 7, 7, 7, 7);
    cyc(1, 0, 1, 7, 32'd88, 0, 0, 7, 7, 7, 7);
    cyc(1, 0, 0, 0, 0, 0, 0, 7, 7, 7, 7);
    cyc(1, 0, 1, 25, 32'd99, 1, 25, 25, 30, 25, 25);
    cyc(1, 0, 0, 0, 0, 0, 0, 25, 30, 25, 25);
    cyc(1, 0, 1, 2, 32'd222, 0, 0, 1, 2, 1, 2);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 2, 1, 2);
    repeat (400) begin
      wa = rnd_a();
      cyc(1, 1'($urandom_range(0, 63) == 0),
          1'($urandom_range(0, 1)), wa, 32'($urandom),
          1'($urandom_range(0, 2) == 0), rnd_a(),
          ($urandom_range(0, 1) != 0) ? wa : rnd_a(),
          rnd_a(), rnd_a(), rnd_a());
    end
    repeat (3) @(negedge clk);
    #1;
    chk("queue_drain", 96'(q.size()), 96'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
